fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the pipelined RISC-V core, successor to the two-source EX-stage forwarding unit. It generates per-source forwarding selects for NUM_SRC register read ports, detects load-use hazards, and tracks one outstanding long-latency operation (MUL/DIV unit) with a countdown scoreboard. The stall output holds PC and IF/ID and injects a bubble into ID/EX. The block sits between the decode/execute pipeline registers and the hazard mux in EX.

## Interface
Parameters:
- NUM_SRC, 2, source register ports per instruction (1..4)
- REG_AW, 5, register address width
- LAT_W, 4, width of long-unit latency field

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_ex_rs  in  NUM_SRC*REG_AW  source regs of instruction in EX; port i at [i*REG_AW +: REG_AW]
- if_id_rs  in  NUM_SRC*REG_AW  source regs of instruction in ID
- if_id_rs_used  in  NUM_SRC  per-source "actually read" flags for the ID instruction
- if_id_rd, if_id_regwrite  in  REG_AW, 1  destination of the ID instruction
- if_id_is_lu  in  1  ID instruction targets the long unit
- id_ex_rd, id_ex_memread  in  REG_AW, 1  EX destination; EX instruction is a load
- ex_mem_rd, ex_mem_regwrite  in  REG_AW, 1  MEM-stage writer
- mem_wb_rd, mem_wb_regwrite  in  REG_AW, 1  WB-stage writer
- lu_issue, lu_rd, lu_lat  in  1, REG_AW, LAT_W  long op issued from EX this cycle, its rd and latency
- flush  in  1  branch flush of IF/ID and ID/EX
- forward_sel  out  NUM_SRC*2  per-source select; port i at [2*i +: 2]
- stall  out  1  hold PC/IF-ID, bubble ID/EX
- stall_cause  out  3  one-hot {struct_lu, raw_lu, load_use}
- lu_busy, lu_done  out  1, 1  scoreboard in BUSY; result on writeback this cycle

## Operation
- Forwarding per source i, priority order: EX/MEM match (ex_mem_regwrite, rd≠0) → FWD_EX_MEM; else scoreboard DONE with lu_rd match, lu_rd≠0 → FWD_LU; else MEM/WB match → FWD_MEM_WB; else FWD_NONE.
- Scoreboard FSM states IDLE, BUSY, DONE; registers pend_rd, cnt[LAT_W-1:0].
- lu_issue in IDLE or DONE: pend_rd←lu_rd, cnt←max(lu_lat,2)−1, next BUSY. lu_lat<2 is treated as 2.
- BUSY: cnt decrements each cycle; cnt==1 → next DONE.
- DONE: lu_done=1 for exactly one cycle; next IDLE unless lu_issue.
- lu_issue in BUSY is a protocol error and is ignored; structural stalling prevents it.
- Stall causes, evaluated combinationally on current state and inputs:
  - load_use: id_ex_memread, id_ex_rd≠0, id_ex_rd equals any used if_id_rs.
  - raw_lu: pending rd ≠0 matches any used if_id_rs, or matches if_id_rd with if_id_regwrite (WAW). Pending rd is lu_rd when lu_issue, else pend_rd when BUSY with cnt>1.
  - struct_lu: if_id_is_lu and (lu_issue or (BUSY and cnt>1)).
- stall = OR of causes. flush forces stall=0 and stall_cause=0. The scoreboard is never flushed, because an issued long op is committed.
- x0 never forwards and never stalls.

## Timing
- forward_sel, stall, stall_cause: combinational, same cycle.
- lu_busy, lu_done: registered-state decode.
- Issue at cycle t with latency L: BUSY t+1..t+L−1, DONE t+L. Dependent ID instruction stalls through cycle t+L−2, enters EX at t+L and receives FWD_LU.
- Reset values: state IDLE, cnt 0, pend_rd 0; all outputs 0.
- rst_n low mid-BUSY: IDLE next edge; the pending op is abandoned.
- Back-to-back long ops: issue in DONE cycle is accepted with no idle gap.

## Configuration
- FWD_HAZARD_PERF_EN defined: adds outputs perf_stall_cycles[31:0] (counts cycles with stall=1) and perf_fwd_events[31:0] (counts cycles where any forward_sel≠FWD_NONE). Both counters wrap at 2^32 and clear on reset.
- Macro undefined: neither the ports nor the counters exist. All other behaviour is identical.

## Structure
- Package fwd_pkg: FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, FWD_LU=2'b11; scoreboard state enum; stall_cause bit indices.
- Sub-module lu_scoreboard: FSM, cnt, pend_rd; exports pending-rd-valid, pend_rd, lu_busy, lu_done.
- Top level holds the per-source forwarding generate loop and the stall logic.

## Test plan
- EX/MEM and MEM/WB both write x5, id_ex_rs0=x5 → forward_sel[1:0]=2'b10; with ex_mem_regwrite=0 → 2'b01; with rd=x0 → 2'b00.
- Load to x7 in EX, ID reads x7 on source 1 with used=1 → stall=1, stall_cause=3'b001. With used=0 → stall=0.
- lu_issue rd=x9 lat=4 at t, ID reads x9 → stall t..t+2, lu_done at t+4, forward_sel=2'b11 at t+4 for the EX source reading x9.
- Long op lat=2 at t with another long op in ID → struct_lu stall at t only; second issue at t+2 during DONE goes straight to BUSY.
- rst_n low at t+1 of a lat=8 op → lu_busy=0 and stall=0 from t+2; a flush during a raw_lu stall → stall=0 that cycle.
- With FWD_HAZARD_PERF_EN defined, 3 stall cycles and 2 forwarding cycles → perf_stall_cycles=3 and perf_fwd_events=2.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard controller: forward selects,
// long-unit scoreboard states and stall_cause bit positions.
package fwd_pkg;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [1:0] FWD_LU     = 2'b11;

    typedef enum logic [1:0] {
        LU_IDLE = 2'd0,
        LU_BUSY = 2'd1,
        LU_DONE = 2'd2
    } lu_state_t;

    localparam int CAUSE_LOAD_USE  = 0;
    localparam int CAUSE_RAW_LU    = 1;
    localparam int CAUSE_STRUCT_LU = 2;

endpackage

// File: rtl/lu_scoreboard.sv
// Countdown scoreboard for the single outstanding MUL/DIV operation.
// Tracks the pending destination and flags BUSY/DONE from registered state.
module lu_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lu_issue,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [LAT_W-1:0]  lu_lat,
    output logic [REG_AW-1:0] pend_rd,
    output logic              pend_vld,
    output logic              lu_busy,
    output logic              lu_done
);

    lu_state_t        state;
    logic [LAT_W-1:0] cnt;

    // Latencies below 2 are stretched to 2 so DONE never lands on the issue edge.
    function automatic logic [LAT_W-1:0] start_cnt(input logic [LAT_W-1:0] lat);
        return (lat < LAT_W'(2)) ? LAT_W'(1) : lat - LAT_W'(1);
    endfunction

    // The result is still in flight (and unforwardable) only while cnt > 1.
    assign pend_vld = (state == LU_BUSY) && (cnt > LAT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LU_IDLE;
            cnt     <= '0;
            pend_rd <= '0;
            lu_busy <= 1'b0;
            lu_done <= 1'b0;
        end else begin
            case (state)
                LU_IDLE, LU_DONE: begin
                    lu_done <= 1'b0;
                    if (lu_issue) begin
                        pend_rd <= lu_rd;
                        cnt     <= start_cnt(lu_lat);
                        state   <= LU_BUSY;
                        lu_busy <= 1'b1;
                    end else begin
                        state   <= LU_IDLE;
                        lu_busy <= 1'b0;
                    end
                end
                LU_BUSY: begin
                    cnt <= cnt - LAT_W'(1);
                    if (cnt <= LAT_W'(1)) begin
                        state   <= LU_DONE;
                        lu_busy <= 1'b0;
                        lu_done <= 1'b1;
                    end else begin
                        lu_busy <= 1'b1;
                        lu_done <= 1'b0;
                    end
                end
                default: begin
                    state   <= LU_IDLE;
                    lu_busy <= 1'b0;
                    lu_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select generation, load-use / long-unit hazard stalls.
// Define FWD_HAZARD_PERF_EN to add the stall and forwarding event counters.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int LAT_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
    input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
    input  logic [NUM_SRC-1:0]        if_id_rs_used,
    input  logic [REG_AW-1:0]         if_id_rd,
    input  logic                      if_id_regwrite,
    input  logic                      if_id_is_lu,
    input  logic [REG_AW-1:0]         id_ex_rd,
    input  logic                      id_ex_memread,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      ex_mem_regwrite,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      mem_wb_regwrite,
    input  logic                      lu_issue,
    input  logic [REG_AW-1:0]         lu_rd,
    input  logic [LAT_W-1:0]          lu_lat,
    input  logic                      flush,
    output logic [NUM_SRC*2-1:0]      forward_sel,
    output logic                      stall,
    output logic [2:0]                stall_cause,
    output logic                      lu_busy,
    output logic                      lu_done
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]               perf_stall_cycles,
    output logic [31:0]               perf_fwd_events
`endif
);

    logic [REG_AW-1:0] pend_rd;
    logic              pend_vld;
    logic [REG_AW-1:0] hz_rd;
    logic              hz_vld;
    logic              load_use;
    logic              raw_lu;
    logic              struct_lu;

    lu_scoreboard #(
        .REG_AW (REG_AW),
        .LAT_W  (LAT_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .lu_issue (lu_issue),
        .lu_rd    (lu_rd),
        .lu_lat   (lu_lat),
        .pend_rd  (pend_rd),
        .pend_vld (pend_vld),
        .lu_busy  (lu_busy),
        .lu_done  (lu_done)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        logic [REG_AW-1:0] rs;
        assign rs = id_ex_rs[i*REG_AW +: REG_AW];
        assign forward_sel[2*i +: 2] =
            (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == rs) ? FWD_EX_MEM :
            (lu_done         && pend_rd   != '0 && pend_rd   == rs) ? FWD_LU     :
            (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == rs) ? FWD_MEM_WB :
                                                                      FWD_NONE;
    end

    // An op issuing this cycle is as much a hazard as one already counting down.
    assign hz_vld = lu_issue || pend_vld;
    assign hz_rd  = lu_issue ? lu_rd : pend_rd;

    always_comb begin
        load_use = 1'b0;
        raw_lu   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (if_id_rs_used[i]) begin
                if (id_ex_memread && id_ex_rd != '0 &&
                    id_ex_rd == if_id_rs[i*REG_AW +: REG_AW])
                    load_use = 1'b1;
                if (hz_vld && hz_rd != '0 && hz_rd == if_id_rs[i*REG_AW +: REG_AW])
                    raw_lu = 1'b1;
            end
        end
        if (hz_vld && hz_rd != '0 && if_id_regwrite && if_id_rd == hz_rd)
            raw_lu = 1'b1;
    end

    assign struct_lu = if_id_is_lu && hz_vld;

    always_comb begin
        stall_cause = 3'b000;
        if (!flush) begin
            stall_cause[CAUSE_LOAD_USE]  = load_use;
            stall_cause[CAUSE_RAW_LU]    = raw_lu;
            stall_cause[CAUSE_STRUCT_LU] = struct_lu;
        end
    end

    assign stall = |stall_cause;

`ifdef FWD_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_fwd_events   <= '0;
        end else begin
            if (stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (|forward_sel)
                perf_fwd_events <= perf_fwd_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: combinational vector table plus
// hand-written scoreboard sequences (perf counters when FWD_HAZARD_PERF_EN).
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  id_ex_rs, if_id_rs;
    logic [1:0]  if_id_rs_used;
    logic [4:0]  if_id_rd, id_ex_rd, ex_mem_rd, mem_wb_rd, lu_rd;
    logic        if_id_regwrite, if_id_is_lu, id_ex_memread;
    logic        ex_mem_regwrite, mem_wb_regwrite, lu_issue, flush;
    logic [3:0]  lu_lat;
    logic [3:0]  forward_sel;
    logic        stall, lu_busy, lu_done;
    logic [2:0]  stall_cause;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_fwd_events;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fwd_hazard_ctrl #(.NUM_SRC(2), .REG_AW(5), .LAT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_ex_rs        (id_ex_rs),
        .if_id_rs        (if_id_rs),
        .if_id_rs_used   (if_id_rs_used),
        .if_id_rd        (if_id_rd),
        .if_id_regwrite  (if_id_regwrite),
        .if_id_is_lu     (if_id_is_lu),
        .id_ex_rd        (id_ex_rd),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .lu_issue        (lu_issue),
        .lu_rd           (lu_rd),
        .lu_lat          (lu_lat),
        .flush           (flush),
        .forward_sel     (forward_sel),
        .stall           (stall),
        .stall_cause     (stall_cause),
        .lu_busy         (lu_busy),
        .lu_done         (lu_done)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_fwd_events   (perf_fwd_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] id_ex_rs;
        logic [9:0] if_id_rs;
        logic [1:0] used;
        logic [4:0] ex_mem_rd;
        logic       ex_mem_rw;
        logic [4:0] mem_wb_rd;
        logic       mem_wb_rw;
        logic [4:0] id_ex_rd;
        logic       memread;
        logic       flush;
        logic [3:0] exp_fwd;
        logic       exp_stall;
        logic [2:0] exp_cause;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_rs = '0; if_id_rs = '0; if_id_rs_used = '0;
        if_id_rd = '0; if_id_regwrite = 1'b0; if_id_is_lu = 1'b0;
        id_ex_rd = '0; id_ex_memread = 1'b0;
        ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
        mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
        lu_issue = 1'b0; lu_rd = '0; lu_lat = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"fwd_exmem",   {5'd0, 5'd5}, 10'd0, 2'b00, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0010, 1'b0, 3'b000};
        vecs[1] = '{"fwd_memwb",   {5'd0, 5'd5}, 10'd0, 2'b00, 5'd5, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'b000};
        vecs[2] = '{"fwd_x0",      {5'd0, 5'd0}, 10'd0, 2'b00, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'b000};
        vecs[3] = '{"fwd_two_src", {5'd6, 5'd5}, 10'd0, 2'b00, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0110, 1'b0, 3'b000};
        vecs[4] = '{"load_use",    10'd0, {5'd7, 5'd3}, 2'b11, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 4'b0000, 1'b1, 3'b001};
        vecs[5] = '{"load_unused", 10'd0, {5'd7, 5'd3}, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000};
        vecs[6] = '{"load_x0",     10'd0, {5'd0, 5'd0}, 2'b11, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'b000};
        vecs[7] = '{"load_flush",  10'd0, {5'd7, 5'd3}, 2'b11, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 4'b0000, 1'b0, 3'b000};

        do_reset();
        #1;
        chk("rst_busy",  lu_busy, 0);
        chk("rst_done",  lu_done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fwd",   forward_sel, 0);

        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            id_ex_rs        = vecs[i].id_ex_rs;
            if_id_rs        = vecs[i].if_id_rs;
            if_id_rs_used   = vecs[i].used;
            ex_mem_rd       = vecs[i].ex_mem_rd;
            ex_mem_regwrite = vecs[i].ex_mem_rw;
            mem_wb_rd       = vecs[i].mem_wb_rd;
            mem_wb_regwrite = vecs[i].mem_wb_rw;
            id_ex_rd        = vecs[i].id_ex_rd;
            id_ex_memread   = vecs[i].memread;
            flush           = vecs[i].flush;
            #1;
            chk({vecs[i].name, "_fwd"},   forward_sel, vecs[i].exp_fwd);
            chk({vecs[i].name, "_stall"}, stall,       vecs[i].exp_stall);
            chk({vecs[i].name, "_cause"}, stall_cause, vecs[i].exp_cause);
        end

        // Long op x9, latency 4: RAW stall t..t+2, DONE and FWD_LU at t+4.
        clear_inputs();
        tick();
        lu_issue = 1'b1; lu_rd = 5'd9; lu_lat = 4'd4;
        if_id_rs = {5'd0, 5'd9}; if_id_rs_used = 2'b01;
        #1;
        chk("lu4_t_stall", stall, 1);
        chk("lu4_t_cause", stall_cause, 3'b010);
        chk("lu4_t_busy",  lu_busy, 0);
        tick();
        lu_issue = 1'b0;
        if_id_rs_used = 2'b00; if_id_rd = 5'd9; if_id_regwrite = 1'b1;
        #1;
        chk("lu4_t1_waw",  stall, 1);
        chk("lu4_t1_busy", lu_busy, 1);
        tick();
        if_id_rs_used = 2'b01; if_id_regwrite = 1'b0;
        #1;
        chk("lu4_t2_stall", stall, 1);
        tick();
        #1;
        chk("lu4_t3_stall", stall, 0);
        chk("lu4_t3_busy",  lu_busy, 1);
        chk("lu4_t3_done",  lu_done, 0);
        tick();
        if_id_rs = '0; if_id_rs_used = '0;
        id_ex_rs = {5'd0, 5'd9};
        #1;
        chk("lu4_t4_done", lu_done, 1);
        chk("lu4_t4_busy", lu_busy, 0);
        chk("lu4_t4_fwd",  forward_sel, 4'b0011);
        tick();
        #1;
        chk("lu4_t5_done", lu_done, 0);
        chk("lu4_t5_fwd",  forward_sel, 4'b0000);

        // Latency 2 with another long op in ID, then back-to-back issue in DONE.
        clear_inputs();
        lu_issue = 1'b1; lu_rd = 5'd3; lu_lat = 4'd2; if_id_is_lu = 1'b1;
        #1;
        chk("lu2_t_stall", stall, 1);
        chk("lu2_t_cause", stall_cause, 3'b100);
        tick();
        lu_issue = 1'b0;
        #1;
        chk("lu2_t1_stall", stall, 0);
        chk("lu2_t1_busy",  lu_busy, 1);
        tick();
        lu_issue = 1'b1; lu_rd = 5'd10; lu_lat = 4'd3; if_id_is_lu = 1'b0;
        #1;
        chk("lu2_t2_done", lu_done, 1);
        tick();
        lu_issue = 1'b0;
        #1;
        chk("b2b_busy", lu_busy, 1);
        chk("b2b_done", lu_done, 0);
        tick();
        tick();
        #1;
        chk("b2b_done2", lu_done, 1);
        tick();

        // Reset during a latency-8 op abandons it.
        clear_inputs();
        lu_issue = 1'b1; lu_rd = 5'd11; lu_lat = 4'd8;
        if_id_rs = {5'd0, 5'd11}; if_id_rs_used = 2'b01;
        tick();
        lu_issue = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstmid_busy",  lu_busy, 0);
        chk("rstmid_stall", stall, 0);

        // Flush masks a raw_lu stall for that cycle only.
        tick();
        lu_issue = 1'b1; lu_rd = 5'd12; lu_lat = 4'd4;
        if_id_rs = {5'd0, 5'd12}; if_id_rs_used = 2'b01; flush = 1'b1;
        #1;
        chk("flush_stall", stall, 0);
        chk("flush_cause", stall_cause, 3'b000);
        tick();
        lu_issue = 1'b0; flush = 1'b0;
        #1;
        chk("postflush_stall", stall, 1);
        chk("postflush_cause", stall_cause, 3'b010);
        for (int i = 0; i < 5; i++) tick();

`ifdef FWD_HAZARD_PERF_EN
        do_reset();
        #1;
        chk("perf_rst_stall", perf_stall_cycles, 0);
        chk("perf_rst_fwd",   perf_fwd_events, 0);
        id_ex_memread = 1'b1; id_ex_rd = 5'd7;
        if_id_rs = {5'd0, 5'd7}; if_id_rs_used = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        clear_inputs();
        id_ex_rs = {5'd0, 5'd5}; ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        clear_inputs();
        tick();
        chk("perf_stall_cycles", perf_stall_cycles, 3);
        chk("perf_fwd_events",   perf_fwd_events, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
